elastic_pipe_reg: RTL
=====================

Name: elastic_pipe_reg

Overview:
Parametrised, multi-stage, valid/ready pipeline register for the CPU datapath. It generalises the fixed stage latch to WIDTH-bit payloads over DEPTH stages. Adds per-stage valid bits, bubble collapsing, an optional input skid buffer, synchronous flush, and occupancy and stall-count observability. Sits between any two pipeline stages, e.g. MEM->WB, where a downstream unit can apply backpressure.

Parameters:
WIDTH, 32, payload bits per entry (1..256)
DEPTH, 2, number of register stages (1..4)
SKID, 1, 1 = registered in_ready with one-entry input skid buffer; 0 = combinational in_ready
STALL_W, 16, stall counter width

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
flush  input  1  synchronous clear of all valid bits (incl. skid)
in_valid  input  1  upstream entry present
in_ready  output  1  block accepts entry this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage DEPTH-1 holds valid entry
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  payload of stage DEPTH-1
occupancy  output  $clog2(DEPTH+2)  count of valid entries, stages plus skid
stall_cnt  output  STALL_W  saturating count of cycles with out_valid && !out_ready

Behaviour:
- Reset (async, high): all valid bits = 0, skid_v = 0, all data regs = 0, stall_cnt = 0.
- While reset is asserted: out_valid = 0, out_data = 0, occupancy = 0, in_ready = 0.
- Stage i holds v[i] and d[i]. out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Advance chain (combinational):
  - adv[DEPTH-1] = !v[DEPTH-1] || out_ready
  - adv[i] = !v[i] || adv[i+1]
  - Bubbles collapse: an empty stage always accepts.
- Stage update on posedge when adv[i]: v[i] <= v[i-1], d[i] <= d[i-1]. Stage 0 takes its source.
- Data regs load only when the incoming valid = 1; otherwise data is held (no toggling on bubbles).
- SKID=0:
  - in_ready = adv[0].
  - Stage-0 source = in_valid/in_data.
- SKID=1:
  - in_ready = !skid_v (registered; no combinational path from out_ready).
  - Stage-0 source = skid entry if skid_v, else in_valid/in_data.
  - Accepted input with adv[0]=0 and skid empty -> captured into skid (skid_v <= 1).
  - Skid drains into stage 0 when adv[0]=1; a simultaneous new input is accepted only if in_ready was 1 that cycle. If it was, the new input goes to skid when skid drained but stage 0 is now occupied.
- Latency: accepted entry appears at out_valid exactly DEPTH cycles later with no backpressure. Throughput 1/cycle when out_ready=1 continuously.
- Ordering: strict FIFO; no entry duplicated or dropped except by flush.
- Capacity: DEPTH entries (SKID=0), DEPTH+1 (SKID=1). in_ready=0 only when full.
- Flush (sync, priority over all transfers at the same edge):
  - All v[i] and skid_v cleared; data regs untouched.
  - Input handshake in a flush cycle is discarded.
  - Output handshake in a flush cycle still counts as delivered downstream.
  - stall_cnt is not cleared.
- occupancy = popcount(v) + skid_v, registered-state derived (combinational from state).
- stall_cnt increments on every posedge with out_valid && !out_ready, saturates at 2^STALL_W-1, cleared only by reset.
- Reset asserted mid-transfer: all state clears asynchronously; in-flight entries are lost. First accept possible on the first posedge after deassertion.

Test Plan:
- Passthrough, DEPTH=3, SKID=0, out_ready=1: in_data=0xA0,0xA1,0xA2 on consecutive cycles -> out_data=0xA0 at cycle 3, 0xA1 at 4, 0xA2 at 5; occupancy peaks at 3.
- Backpressure, DEPTH=2, SKID=1: out_ready=0, stream 0x10..0x14 -> 3 accepted (0x10,0x11,0x12); in_ready=0 from next cycle; occupancy=3; stall_cnt counts from first out_valid. Release out_ready -> 0x10,0x11,0x12 in order, then 0x13,0x14.
- Bubble collapse, DEPTH=4: inject 0x1, idle 2 cycles, inject 0x2, hold out_ready=0 -> both compact into stages 3 and 2; occupancy=2; in_ready stays 1.
- Flush with simultaneous handshakes: full pipe, flush=1 with in_valid=1 (0xFF) and out_ready=1 -> next cycle out_valid=0, occupancy=0; 0xFF never appears; stall_cnt unchanged.
- Reset mid-operation: occupancy=2, assert reset between edges -> out_valid and occupancy go 0 immediately, stall_cnt=0. After release, 0x55 emerges DEPTH cycles after acceptance.
- Saturation, STALL_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/elastic_pipe_reg_if.sv
// Valid/ready handshake bundle for elastic_pipe_reg: upstream (in_*) and downstream (out_*) sides.
interface elastic_pipe_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/elastic_pipe_reg.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, optional input skid buffer,
// synchronous flush, occupancy and saturating stall counter.
module elastic_pipe_reg #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned SKID    = 1,
    parameter int unsigned STALL_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    elastic_pipe_reg_if.slave          bus,
    output logic [$clog2(DEPTH+2)-1:0] occupancy,
    output logic [STALL_W-1:0]         stall_cnt
);
    localparam int unsigned OccW = $clog2(DEPTH + 2);

    logic [DEPTH-1:0]   v_q, v_d, adv;
    logic [WIDTH-1:0]   d_q [DEPTH];
    logic [WIDTH-1:0]   d_d [DEPTH];
    logic               skid_v_q, skid_v_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               in_rdy, accept, src_v;
    logic [WIDTH-1:0]   src_data;
    logic [OccW-1:0]    occ;

    // Ripple advance from the output end: an empty stage always accepts.
    always_comb begin
        logic a;
        a              = !v_q[DEPTH-1] || bus.out_ready;
        adv[DEPTH-1]   = a;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            a      = !v_q[i] || a;
            adv[i] = a;
        end
    end

    always_comb begin
        if (SKID != 0) begin
            in_rdy = !skid_v_q && !reset;
        end else begin
            in_rdy = adv[0] && !reset;
        end
        accept   = bus.in_valid && in_rdy && !flush;
        src_v    = accept;
        src_data = bus.in_data;
        if (SKID != 0 && skid_v_q) begin
            src_v    = 1'b1;
            src_data = skid_data_q;
        end
    end

    always_comb begin
        v_d         = v_q;
        d_d         = d_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        stall_d     = stall_q;
        if (flush) begin
            v_d      = '0;
            skid_v_d = 1'b0;
        end else begin
            if (adv[0]) begin
                v_d[0] = src_v;
                if (src_v) d_d[0] = src_data;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) d_d[i] = d_q[i-1];
                end
            end
            if (SKID != 0) begin
                if (skid_v_q && adv[0]) begin
                    skid_v_d = 1'b0;
                end else if (!skid_v_q && accept && !adv[0]) begin
                    skid_v_d    = 1'b1;
                    skid_data_d = bus.in_data;
                end
            end
        end
        if (v_q[DEPTH-1] && !bus.out_ready && stall_q != {STALL_W{1'b1}}) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_comb begin
        occ = OccW'(skid_v_q);
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ = occ + OccW'(v_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q         <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            stall_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q         <= v_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_data  = d_q[DEPTH-1];
    assign occupancy     = occ;
    assign stall_cnt     = stall_q;
endmodule
